// File: rtl/telemetry_pkt.sv
// Periodic telemetry packetizer: snapshots NUM_CH channels every PERIOD
// cycles and frames them as AA 55, {hi, lo} per channel, optional checksum,
// handing bytes one at a time to an external UART_tx (trmt/tx_data/tx_done).
module telemetry_pkt #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 12,
  parameter int PERIOD = 1048576,
  parameter int CHK_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     tx_done,
  output logic                     trmt,
  output logic [7:0]               tx_data,
  output logic                     busy,
  output logic                     pkt_done,
  output logic                     overrun
);

  localparam int PKT_LEN = 2 + 2 * NUM_CH + ((CHK_EN != 0) ? 1 : 0);
  localparam int CNT_W   = $clog2(PERIOD);
  localparam int IDX_W   = 6;  // PKT_LEN is at most 35

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                    state;
  logic [CNT_W-1:0]          period_cnt;
  logic                      pending;
  logic [IDX_W-1:0]          byte_idx;
  logic [NUM_CH*DATA_W-1:0]  snap;

  logic                      tick;
  logic                      start;
  logic [IDX_W-1:0]          next_idx;
  logic [4:0]                ch_sel;
  logic [15:0]               ch_wide;
  logic [15:0]               sum_wide;
  logic [7:0]                sum;
  logic [7:0]                chk;
  logic [7:0]                next_byte;

  assign tick     = en && (period_cnt == CNT_W'(PERIOD - 1));
  // The IDLE cycle in which busy is still high (pkt_done cycle) never starts
  // a packet, so a pending tick launches the next packet one cycle later.
  assign start    = (state == IDLE) && !busy && en && pending;
  assign next_idx = byte_idx + IDX_W'(1);

  // Checksum: negated mod-256 sum of every payload byte of the snapshot
  always_comb begin
    // NOTE: every variable gets a value before any branch or loop so that no latch is inferred.
    sum      = '0;
    sum_wide = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum_wide = 16'(snap[i*DATA_W +: DATA_W]);
      sum      = sum + sum_wide[15:8] + sum_wide[7:0];
    end
    chk = 8'h00 - sum;
  end

  // Byte that follows byte_idx in the frame, taken from the snapshot
  always_comb begin
    next_byte = chk;
    ch_sel    = '0;
    ch_wide   = '0;
    if (next_idx == IDX_W'(0)) begin
      next_byte = 8'hAA;
    end else if (next_idx == IDX_W'(1)) begin
      next_byte = 8'h55;
    end else if (next_idx < IDX_W'(2 + 2 * NUM_CH)) begin
      ch_sel    = 5'((next_idx - IDX_W'(2)) >> 1);
      ch_wide   = 16'(snap[ch_sel*DATA_W +: DATA_W]);
      next_byte = next_idx[0] ? ch_wide[7:0] : ch_wide[15:8];
    end
  end

  // Period counter, pending flag and framing FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      period_cnt <= '0;
      pending    <= 1'b1;
      byte_idx   <= '0;
      // NOTE: the snapshot is reset too; it is only a few flops and keeps the checksum path free of X after reset.
      snap       <= '0;
      trmt       <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      pkt_done   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees the previous-cycle values.
      trmt     <= 1'b0;
      pkt_done <= 1'b0;
      overrun  <= tick && busy;

      if (start || !en || tick) period_cnt <= '0;
      else                      period_cnt <= period_cnt + CNT_W'(1);

      if (start)     pending <= 1'b0;
      else if (tick) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            snap     <= ch_data;
            byte_idx <= '0;
            trmt     <= 1'b1;
            tx_data  <= 8'hAA;
            busy     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (tx_done) begin
            if (byte_idx == IDX_W'(PKT_LEN - 1)) begin
              pkt_done <= 1'b1;
              state    <= IDLE;
            end else begin
              byte_idx <= next_idx;
              trmt     <= 1'b1;
              tx_data  <= next_byte;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_telemetry_pkt.sv
// Scoreboard bench for telemetry_pkt: stimulus pushes the expected frame for
// each snapshot, a monitor pops and compares every trmt byte and checks
// handshake timing, packet spacing and overrun counts against a simple model.
module tb_telemetry_pkt;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 12;
  localparam int PERIOD = 64;
  localparam int CHK_EN = 1;
  localparam int W      = NUM_CH * DATA_W;

  typedef struct {
    logic [7:0] b;
    bit         first;
    bit         last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [W-1:0]  ch_data;
  logic          uart_done;
  logic          stray_done;
  logic          tx_done;
  logic          trmt;
  logic [7:0]    tx_data;
  logic          busy;
  logic          pkt_done;
  logic          overrun;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   dly   = 3;

  exp_t exp_q[$];
  exp_t cur_e;
  int   n_starts = 0, n_pd = 0, n_trmt = 0, frame_pos = 0, ovr_cnt = 0;
  int   s_prev = 0, pd_prev = 0, last_done = 0;
  bit   spacing_ok = 0, in_frame = 0, cur_last = 0, pd_exp = 0, prev_trmt = 0;
  logic [7:0] held = 8'h00;

  assign tx_done = uart_done | stray_done;

  telemetry_pkt #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .PERIOD(PERIOD), .CHK_EN(CHK_EN)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ch_data(ch_data), .tx_done(tx_done),
    .trmt(trmt), .tx_data(tx_data), .busy(busy), .pkt_done(pkt_done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, want);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at cycle %0d: timed out waiting for DUT", name, cyc);
  endtask

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int i = 0; i < NUM_CH; i++) r[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    return r;
  endfunction

  // Reference frame: header, hi/lo of each channel, negated byte sum
  task automatic push_frame(input logic [W-1:0] v);
    exp_t f[$];
    int   sum = 0;
    int   c;
    f.push_back('{8'hAA, 1'b1, 1'b0});
    f.push_back('{8'h55, 1'b0, 1'b0});
    for (int i = 0; i < NUM_CH; i++) begin
      c = int'(v[i*DATA_W +: DATA_W]);
      f.push_back('{8'(c / 256), 1'b0, 1'b0});
      f.push_back('{8'(c % 256), 1'b0, 1'b0});
      sum += c / 256 + c % 256;
    end
    if (CHK_EN != 0) f.push_back('{8'((256 - sum % 256) % 256), 1'b0, 1'b0});
    f[f.size()-1].last = 1'b1;
    foreach (f[i]) exp_q.push_back(f[i]);
  endtask

  // Next first-trmt: one cycle after the tick-driven start, or two cycles
  // after pkt_done when the tick already landed while the packet was busy.
  function automatic int exp_spacing();
    int a = pd_prev + 2;
    int b = s_prev + PERIOD + 1;
    return ((a > b) ? a : b) - s_prev;
  endfunction

  function automatic int exp_overruns();
    int n = 0;
    for (int k = 1; s_prev + k * PERIOD - 1 <= pd_prev; k++) n++;
    return n;
  endfunction

  // UART_tx model: tx_done pulse dly cycles after each trmt
  initial begin
    uart_done = 1'b0;
    forever begin
      @(negedge clk);
      if (trmt && !rst) begin
        repeat (dly) @(posedge clk);
        #1 uart_done = 1'b1;
        @(posedge clk);
        #1 uart_done = 1'b0;
      end
    end
  end

  // Monitor: pops expected bytes and checks handshake timing
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        in_frame   = 0;
        pd_exp     = 0;
        prev_trmt  = 0;
        spacing_ok = 0;
      end else begin
        if (!en) spacing_ok = 0;
        if (pkt_done || pd_exp) begin
          check("pkt_done", pkt_done, pd_exp);
          if (pkt_done) begin
            pd_prev  = cyc;
            in_frame = 0;
            n_pd++;
          end
        end
        pd_exp = 0;
        if (trmt) begin
          check("no_b2b_trmt", prev_trmt, 0);
          n_trmt++;
          if (exp_q.size() == 0) begin
            check("unexpected_trmt", 1, 0);
          end else begin
            cur_e = exp_q.pop_front();
            check("tx_byte", tx_data, cur_e.b);
            if (cur_e.first) begin
              if (spacing_ok) begin
                check("start_spacing", cyc - s_prev, exp_spacing());
                check("overrun_count", ovr_cnt, exp_overruns());
              end
              s_prev     = cyc;
              ovr_cnt    = 0;
              spacing_ok = 1;
              frame_pos  = 0;
              n_starts++;
            end else begin
              check("done_to_trmt", cyc - last_done, 1);
              frame_pos++;
            end
            in_frame = 1;
            cur_last = cur_e.last;
            held     = tx_data;
          end
        end
        if (tx_done && in_frame) begin
          check("tx_data_hold", tx_data, held);
          last_done = cyc;
          pd_exp    = cur_last;
        end
        if (overrun) ovr_cnt++;
        prev_trmt = trmt;
      end
    end
  end

  task automatic wait_pos(input int tgt, input int pos);
    int t = 0;
    while (!(n_starts == tgt && frame_pos >= pos) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 3000) timeout_fail("wait_pos");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pd(input int tgt);
    int t = 0;
    while (n_pd < tgt && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 3000) timeout_fail("wait_pkt_done");
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_trmt"},     trmt,     0);
    check({tag, "_tx_data"},  tx_data,  0);
    check({tag, "_busy"},     busy,     0);
    check({tag, "_pkt_done"}, pkt_done, 0);
    check({tag, "_overrun"},  overrun,  0);
  endtask

  // Stimulus
  initial begin
    int t0;
    int c0;
    rst        = 1'b1;
    en         = 1'b0;
    stray_done = 1'b0;
    ch_data    = {12'hFFF, 12'h123, 12'hABC};
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");

    // Short UART delay: packets fit inside the period, no overrun
    @(posedge clk);
    #1 rst = 1'b0;
    push_frame(ch_data);
    en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      wait_pos(k + 1, 3);
      if (k == 0)      ch_data[DATA_W-1:0] = 12'h555;
      else if (k == 1) ch_data = '1;
      else if (k == 2) ch_data = '0;
      else             ch_data = rnd();
      push_frame(ch_data);
      // Long UART delay: packets outlast the period, ticks land while busy
      if (k == 3) dly = 10;
    end

    // en dropped after the tick of packet 8: packet completes, pending kept
    wait_pos(8, 6);
    en = 1'b0;
    wait_pd(8);
    check("queue_drained_after_en_drop", exp_q.size(), 0);
    t0 = n_trmt;
    repeat (50) @(posedge clk);
    #1 stray_done = 1'b1;
    @(posedge clk);
    #1 stray_done = 1'b0;
    repeat (150) @(posedge clk);
    #1 check("idle_no_trmt", n_trmt, t0);
    ch_data = rnd();
    push_frame(ch_data);
    en = 1'b1;
    c0 = cyc;
    for (int t = 0; t < 6 && n_starts != 9; t++) @(negedge clk);
    if (n_starts != 9) timeout_fail("restart_after_en");
    else               check("restart_within_2", (s_prev - c0) <= 2, 1);

    // Reset in the middle of the restarted packet
    dly = 3;
    wait_pos(9, 5);
    rst = 1'b1;
    #1 check_outputs_zero("mid_rst");
    repeat (15) @(posedge clk);
    #1 rst = 1'b0;
    ch_data = rnd();
    push_frame(ch_data);
    wait_pd(9);
    en = 1'b0;
    check("queue_drained_final", exp_q.size(), 0);
    check("packets_started", n_starts, 10);
    repeat (20) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
